task3_fetch_unit: RTL and testbench

//  Instruction fetch stage in front of the 10-bit instruction ROM (task3rom). Holds the program

---
 rtl/task3_pkg.sv | 18 +
 rtl/task3_pc_reg.sv | 25 ++
 rtl/task3_fetch_unit.sv | 81 ++++++++
 tb/tb_task3_fetch_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/task3_pkg.sv
// Shared constants and types for the task3 instruction fetch stage.
package task3_pkg;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned INSTR_W = 10;
    localparam logic [INSTR_W-1:0] HALT_INSTR = '0;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_slot_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } run_state_t;

endpackage

// File: rtl/task3_pc_reg.sv
// Program counter: redirect load, advance with wrap at LAST_ADDR, otherwise hold.
module task3_pc_reg #(
    parameter int unsigned       ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [ADDR_W-1:0] LAST_ADDR = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              advance,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (advance) begin
            pc <= (pc == LAST_ADDR) ? '0 : pc + 1'b1;
        end
    end

endmodule

// File: rtl/task3_fetch_unit.sv
// Fetch stage: drives ROM address from pc, registers {pc, instr} into an output
// slot and hands it to decode over valid/ready; supports redirect, halt and a fetch counter.
module task3_fetch_unit #(
    parameter int unsigned        ADDR_W     = task3_pkg::ADDR_W,
    parameter int unsigned        INSTR_W    = task3_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter logic [ADDR_W-1:0]  LAST_ADDR  = '1,
    parameter logic [INSTR_W-1:0] HALT_INSTR = task3_pkg::HALT_INSTR,
    parameter int unsigned        CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               halted,
    output logic [CNT_W-1:0]   fetch_count
);

    import task3_pkg::*;

    logic [ADDR_W-1:0] pc;
    logic              fire;
    logic              is_halt;
    fetch_slot_t       slot;
    run_state_t        state;

    assign fire    = (state == RUN) && !redirect_valid && (!out_valid || out_ready);
    assign is_halt = (rom_data == HALT_INSTR);

    // A fetched halt word is delivered but leaves pc pointing at itself.
    task3_pc_reg #(
        .ADDR_W    (ADDR_W),
        .RESET_PC  (RESET_PC),
        .LAST_ADDR (LAST_ADDR)
    ) u_pc_reg (
        .clk     (clk),
        .reset   (reset),
        .load    (redirect_valid),
        .load_pc (redirect_pc),
        .advance (fire && !is_halt),
        .pc      (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            slot        <= '0;
            out_valid   <= 1'b0;
            state       <= RUN;
            fetch_count <= '0;
        end else begin
            if (out_valid && out_ready && !redirect_valid && (fetch_count != '1)) begin
                fetch_count <= fetch_count + 1'b1;
            end
            if (redirect_valid) begin
                out_valid <= 1'b0;
                state     <= RUN;
            end else if (fire) begin
                slot.pc    <= pc;
                slot.instr <= rom_data;
                out_valid  <= 1'b1;
                if (is_halt) begin
                    state <= HALTED;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign rom_addr  = pc;
    assign out_pc    = slot.pc;
    assign out_instr = slot.instr;
    assign halted    = (state == HALTED);

endmodule

// File: tb/tb_task3_fetch_unit.sv
// Directed bench for task3_fetch_unit with a 12-word ROM model (LAST_ADDR = 11).
module tb_task3_fetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] rom_addr;
    logic [9:0] rom_data;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_instr;
    logic [9:0] out_pc;
    logic       redirect_valid;
    logic [9:0] redirect_pc;
    logic       halted;
    logic [15:0] fetch_count;

    logic       reset2;
    logic       ready2;
    logic [9:0] rom_addr2;
    logic [9:0] rom_data2;
    logic       valid2;
    logic [9:0] instr2;
    logic [9:0] pc2;
    logic       halted2;
    logic [2:0] count2;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [9:0] rom [0:15];

    always #5 clk = ~clk;

    always_comb begin
        rom_data  = (rom_addr  <= 10'd11) ? rom[rom_addr[3:0]]  : 10'h3FF;
        rom_data2 = (rom_addr2 <= 10'd11) ? rom[rom_addr2[3:0]] : 10'h3FF;
    end

    task3_fetch_unit #(
        .LAST_ADDR (10'd11)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    // Narrow counter instance to reach the saturation point quickly.
    task3_fetch_unit #(
        .LAST_ADDR (10'd11),
        .CNT_W     (3)
    ) dut_sat (
        .clk            (clk),
        .reset          (reset2),
        .rom_addr       (rom_addr2),
        .rom_data       (rom_data2),
        .out_valid      (valid2),
        .out_ready      (ready2),
        .out_instr      (instr2),
        .out_pc         (pc2),
        .redirect_valid (1'b0),
        .redirect_pc    (10'd0),
        .halted         (halted2),
        .fetch_count    (count2)
    );

    typedef struct {
        logic        ready;
        logic        redir;
        logic [9:0]  rpc;
        logic        exp_valid;
        logic [9:0]  exp_pc;
        logic [9:0]  exp_instr;
        logic        exp_halted;
        logic [15:0] exp_cnt;
        logic [9:0]  exp_addr;
    } vec_t;

    localparam logic [9:0] W0  = 10'b1100010000;
    localparam logic [9:0] W1  = 10'b1100011001;
    localparam logic [9:0] W2  = 10'b1101011100;
    localparam logic [9:0] W3  = 10'b0001010101;
    localparam logic [9:0] W4  = 10'b0110010011;
    localparam logic [9:0] W9  = 10'b1010110110;
    localparam logic [9:0] W10 = 10'b1001111010;
    localparam logic [9:0] W11 = 10'b0010000010;
    localparam logic [9:0] HLT = 10'b0000000000;

    vec_t vecs [24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " out_valid"},   {31'd0, out_valid},   32'd0);
        check({tag, " out_pc"},      {22'd0, out_pc},      32'd0);
        check({tag, " out_instr"},   {22'd0, out_instr},   32'd0);
        check({tag, " halted"},      {31'd0, halted},      32'd0);
        check({tag, " fetch_count"}, {16'd0, fetch_count}, 32'd0);
        check({tag, " rom_addr"},    {22'd0, rom_addr},    32'd0);
    endtask

    initial begin
        rom[0]  = W0;           rom[1]  = W1;           rom[2]  = W2;
        rom[3]  = W3;           rom[4]  = W4;           rom[5]  = 10'b0100101101;
        rom[6]  = 10'b0011001100; rom[7] = 10'b0111000111; rom[8] = 10'b1000110001;
        rom[9]  = W9;           rom[10] = W10;          rom[11] = W11;
        rom[12] = 10'h3FF;      rom[13] = 10'h3FF;      rom[14] = 10'h3FF;
        rom[15] = 10'h3FF;

        // ready, redir, rpc, exp: valid, pc, instr, halted, count, rom_addr
        vecs[0]  = '{1'b1, 1'b0, 10'd0, 1'b1, 10'd0,  W0,  1'b0, 16'd0,  10'd1};
        vecs[1]  = '{1'b1, 1'b0, 10'd0, 1'b1, 10'd1,  W1,  1'b0, 16'd1,  10'd2};
        vecs[2]  = '{1'b1, 1'b0, 10'd0, 1'b1, 10'd2,  W2,  1'b0, 16'd2,  10'd3};
        vecs[3]  = '{1'b0, 1'b0, 10'd0, 1'b1, 10'd2,  W2,  1'b0, 16'd2,  10'd3};
        vecs[4]  = '{1'b0, 1'b0, 10'd0, 1'b1, 10'd2,  W2,  1'b0, 16'd2,  10'd3};
        vecs[5]  = '{1'b0, 1'b0, 10'd0, 1'b1, 10'd2,  W2,  1'b0, 16'd2,  10'd3};
        vecs[6]  = '{1'b0, 1'b0, 10'd0, 1'b1, 10'd2,  W2,  1'b0, 16'd2,  10'd3};
        vecs[7]  = '{1'b1, 1'b0, 10'd0, 1'b1, 10'd3,  W3,  1'b0, 16'd3,  10'd4};
        vecs[8]  = '{1'b1, 1'b0, 10'd0, 1'b1, 10'd4,  W4,  1'b0, 16'd4,  10'd5};
        vecs[9]  = '{1'b1, 1'b1, 10'd9, 1'b0, 10'd0,  W0,  1'b0, 16'd4,  10'd9};
        vecs[10] = '{1'b1, 1'b0, 10'd0, 1'b1, 10'd9,  W9,  1'b0, 16'd4,  10'd10};
        vecs[11] = '{1'b1, 1'b0, 10'd0, 1'b1, 10'd10, W10, 1'b0, 16'd5,  10'd11};
        vecs[12] = '{1'b1, 1'b0, 10'd0, 1'b1, 10'd11, W11, 1'b0, 16'd6,  10'd0};
        vecs[13] = '{1'b1, 1'b0, 10'd0, 1'b1, 10'd0,  W0,  1'b0, 16'd7,  10'd1};
        vecs[14] = '{1'b1, 1'b0, 10'd0, 1'b1, 10'd1,  W1,  1'b0, 16'd8,  10'd2};
        vecs[15] = '{1'b1, 1'b0, 10'd0, 1'b1, 10'd2,  W2,  1'b0, 16'd9,  10'd3};
        vecs[16] = '{1'b1, 1'b0, 10'd0, 1'b1, 10'd3,  W3,  1'b0, 16'd10, 10'd4};
        vecs[17] = '{1'b1, 1'b0, 10'd0, 1'b1, 10'd4,  W4,  1'b0, 16'd11, 10'd5};
        vecs[18] = '{1'b1, 1'b0, 10'd0, 1'b1, 10'd5,  HLT, 1'b1, 16'd12, 10'd5};
        vecs[19] = '{1'b1, 1'b0, 10'd0, 1'b0, 10'd0,  W0,  1'b1, 16'd13, 10'd5};
        vecs[20] = '{1'b1, 1'b0, 10'd0, 1'b0, 10'd0,  W0,  1'b1, 16'd13, 10'd5};
        vecs[21] = '{1'b1, 1'b1, 10'd0, 1'b0, 10'd0,  W0,  1'b0, 16'd13, 10'd0};
        vecs[22] = '{1'b1, 1'b0, 10'd0, 1'b1, 10'd0,  W0,  1'b0, 16'd13, 10'd1};
        vecs[23] = '{1'b1, 1'b0, 10'd0, 1'b1, 10'd1,  W1,  1'b0, 16'd14, 10'd2};

        reset          = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        reset2         = 1'b1;
        ready2         = 1'b0;
        step();
        step();
        check_reset_state("reset");

        // Saturating counter: edge k after reset release has k-1 handshakes, capped at 7.
        reset2 = 1'b0;
        ready2 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("sat count edge %0d", k), {29'd0, count2},
                  (k - 1 > 7) ? 32'd7 : 32'(k - 1));
        end
        check("sat valid", {31'd0, valid2}, 32'd1);

        rom[5] = HLT;
        reset  = 1'b0;
        for (int i = 0; i < 24; i++) begin
            out_ready      = vecs[i].ready;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            step();
            check($sformatf("v%0d out_valid", i),   {31'd0, out_valid},   {31'd0, vecs[i].exp_valid});
            check($sformatf("v%0d halted", i),      {31'd0, halted},      {31'd0, vecs[i].exp_halted});
            check($sformatf("v%0d fetch_count", i), {16'd0, fetch_count}, {16'd0, vecs[i].exp_cnt});
            check($sformatf("v%0d rom_addr", i),    {22'd0, rom_addr},    {22'd0, vecs[i].exp_addr});
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d out_pc", i),    {22'd0, out_pc},    {22'd0, vecs[i].exp_pc});
                check($sformatf("v%0d out_instr", i), {22'd0, out_instr}, {22'd0, vecs[i].exp_instr});
            end
        end

        // Stall with slot {1, W1} held, then reset lands mid-stall.
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        step();
        check("stall2 valid", {31'd0, out_valid}, 32'd1);
        check("stall2 pc",    {22'd0, out_pc},    32'd1);
        check("stall2 count", {16'd0, fetch_count}, 32'd14);
        reset = 1'b1;
        step();
        check_reset_state("mid-stall reset");
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        check("post-reset pc",    {22'd0, out_pc},    32'd0);
        check("post-reset instr", {22'd0, out_instr}, {22'd0, W0});
        check("post-reset valid", {31'd0, out_valid}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
